// File: rtl/mod_dds_sum.sv
// -----------------------------------------------------------------------------
// mod_dds_sum
//
// Sums NCH two's-complement DDS channel samples through a registered binary
// adder tree, then rounds, shifts, and saturates or wraps the result to a B-bit
// output sample. A sticky overflow flag and a saturating overflow counter
// report output samples that did not fit in B bits.
//
// Pipeline (latency LOG2N + 2 cycles, the same for data and valid):
//   stage 0          : per-channel enable gating and sign extension to BA bits
//   stages 1..LOG2N  : pairwise adder tree, reducing NCH terms to one sum
//   output register  : round, shift, overflow detection, saturate or wrap
//
// Ports
//   m_axis_aclk     in   1      clock; all logic on the rising edge
//   m_axis_aresetn  in   1      synchronous active-low reset
//   din             in   NCH*B  packed samples, channel k at [k*B +: B]
//   din_valid       in   1      qualifies din; there is no backpressure
//   EN_REG          in   NCH    per-channel enable (0 drops that channel)
//   QSEL_REG        in   4      right-shift amount, clamped to LOG2N
//   RND_REG         in   1      1 = round half up before the shift, 0 = truncate
//   SAT_REG         in   1      1 = saturate to B bits, 0 = wrap
//   CLR_REG         in   1      one-cycle pulse clearing the overflow status
//   m_axis_tvalid   out  1      output sample valid
//   m_axis_tdata    out  B      quantized sum; holds its value between valids
//   ovf_flag        out  1      sticky overflow indicator
//   ovf_cnt         out  16     overflowing valid outputs, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module mod_dds_sum #(
   parameter int NCH = 16,
   parameter int B   = 16
) (
   input  logic               m_axis_aclk,
   input  logic               m_axis_aresetn,
   input  logic [NCH*B-1:0]   din,
   input  logic               din_valid,
   input  logic [NCH-1:0]     EN_REG,
   input  logic [3:0]         QSEL_REG,
   input  logic               RND_REG,
   input  logic               SAT_REG,
   input  logic               CLR_REG,
   output logic               m_axis_tvalid,
   output logic [B-1:0]       m_axis_tdata,
   output logic               ovf_flag,
   output logic [15:0]        ovf_cnt
);

   localparam int LOG2N = $clog2(NCH);
   localparam int BA    = B + LOG2N;
   // Tree nodes stored level by level: leaves at 0..NCH-1, root at NODES-1.
   localparam int NODES = 2 * NCH - 1;
   localparam logic [3:0] SMAX = 4'(LOG2N);

   // Largest and smallest B-bit values, sign-extended to the rounding width.
   localparam logic signed [BA:0] MAXV = {{(LOG2N + 2){1'b0}}, {(B - 1){1'b1}}};
   localparam logic signed [BA:0] MINV = {{(LOG2N + 2){1'b1}}, {(B - 1){1'b0}}};

   logic signed [BA-1:0] tree_p [NODES];
   logic [LOG2N:0]       vld_p;

   logic [3:0]           s_eff;
   logic signed [BA:0]   sum_rnd;
   logic signed [BA:0]   sum_q;
   logic                 sample_ovf;
   logic [B-1:0]         q_out;

   // Adds half an output LSB when rounding is on and the shift is non-zero.
   // One extra bit of headroom keeps the addition from wrapping.
   function automatic logic signed [BA:0] round_add(
      input logic signed [BA-1:0] x,
      input logic [3:0]           s,
      input logic                 rnd
   );
      logic signed [BA:0] half;
      half = '0;
      if (rnd && (s != 4'd0))
         half = $signed((BA + 1)'(1) << (s - 4'd1));
      return $signed({x[BA-1], x}) + half;
   endfunction

   function automatic logic is_ovf(input logic signed [BA:0] q);
      return (q > MAXV) || (q < MINV);
   endfunction

   // Clamp to the nearer B-bit bound when saturating; otherwise keep low bits.
   function automatic logic [B-1:0] quantize(
      input logic signed [BA:0] q,
      input logic               sat
   );
      logic [B-1:0] res;
      res = q[B-1:0];
      if (sat) begin
         if (q > MAXV)
            res = MAXV[B-1:0];
         else if (q < MINV)
            res = MINV[B-1:0];
      end
      return res;
   endfunction

   // ---- stage 0: enable gating and sign extension ----
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      always_ff @(posedge m_axis_aclk) begin
         if (!m_axis_aresetn)
            tree_p[k] <= '0;
         else if (EN_REG[k])
            tree_p[k] <= {{LOG2N{din[k*B + B - 1]}}, din[k*B +: B]};
         else
            tree_p[k] <= '0;
      end
   end

   // The valid bit shifts through stage 0 and every adder level every cycle,
   // whether or not the sample it describes is valid.
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn)
         vld_p <= '0;
      else
         vld_p <= {vld_p[LOG2N-1:0], din_valid};
   end

   // ---- stages 1..LOG2N: pairwise adder tree ----
   // Each level grows by one bit of headroom in aggregate, so a BA-bit
   // accumulator holds the full sum of NCH B-bit terms without overflow.
   for (genvar lv = 1; lv <= LOG2N; lv++) begin : g_lvl
      localparam int OFF_IN  = 2 * NCH - 2 * (NCH >> (lv - 1));
      localparam int OFF_OUT = 2 * NCH - 2 * (NCH >> lv);
      for (genvar i = 0; i < (NCH >> lv); i++) begin : g_add
         always_ff @(posedge m_axis_aclk) begin
            if (!m_axis_aresetn)
               tree_p[OFF_OUT + i] <= '0;
            else
               tree_p[OFF_OUT + i] <= tree_p[OFF_IN + 2*i] + tree_p[OFF_IN + 2*i + 1];
         end
      end
   end

   // ---- output stage: round, shift, overflow detect, quantize ----
   // QSEL/RND/SAT act on whichever sample sits at the tree root this cycle.
   always_comb begin
      s_eff      = (QSEL_REG > SMAX) ? SMAX : QSEL_REG;
      sum_rnd    = round_add(tree_p[NODES-1], s_eff, RND_REG);
      sum_q      = sum_rnd >>> s_eff;
      sample_ovf = vld_p[LOG2N] && is_ovf(sum_q);
      q_out      = quantize(sum_q, SAT_REG);
   end

   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         m_axis_tvalid <= vld_p[LOG2N];
         if (vld_p[LOG2N])
            m_axis_tdata <= q_out;
      end
   end

   // A clear coinciding with an overflow leaves that overflow recorded,
   // so no event is lost across the clear.
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else if (CLR_REG) begin
         ovf_flag <= sample_ovf;
         ovf_cnt  <= sample_ovf ? 16'd1 : 16'd0;
      end else if (sample_ovf) begin
         ovf_flag <= 1'b1;
         if (ovf_cnt != 16'hFFFF)
            ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

endmodule
